load_store_unit: RTL and testbench

- Initiator-side master for the word-only data memory (byte address, word-aligned access, combinational read, write on posedge CLK).
- Accepts RV32 load/store requests from the core and performs byte, halfword and word accesses with sign/zero extension.
- Implements sub-word stores by read-modify-write.
- Optionally splits misaligned accesses that span two memory words.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_byte_lane.sv | 80 ++++++++
 rtl/load_store_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 encodings, FSM state type and access-size decode
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RESP = 3'd5
    } lsu_state_t;

    // Byte count of an access; 0 marks an encoding with no defined size.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            F3_W:        f3_size = 3'd4;
            default:     f3_size = 3'd0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3_size(f3) != 3'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_lane.sv
// ============================================================================
// Module      : lsu_byte_lane
// Description : Combinational load extract/extend and store byte merge.
//               LSU_MISALIGN_SPLIT_EN adds the second (upper) memory word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_buf0,
`ifdef LSU_MISALIGN_SPLIT_EN
    input  logic [XLEN-1:0] i_buf1,
`endif
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_size,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_load,
`ifdef LSU_MISALIGN_SPLIT_EN
    output logic [XLEN-1:0] o_wr1,
`endif
    output logic [XLEN-1:0] o_wr0
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int W = 2 * XLEN;
`else
    localparam int W = XLEN;
`endif

    logic [W-1:0]    w_dw;
    logic [W-1:0]    w_wd;
    logic [W-1:0]    w_mrg;
    logic [XLEN-1:0] w_sh;
    int              w_lo;
    int              w_hi;

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_dw = {i_buf1, i_buf0};
`else
    assign w_dw = i_buf0;
`endif

    assign w_lo = int'(i_off);
    assign w_hi = w_lo + int'(i_size);
    assign w_wd = W'(i_wdata) << (8 * w_lo);
    assign w_sh = XLEN'(w_dw >> (8 * w_lo));

    // Store bytes occupy lanes [off, off+size) of the little-endian word pair.
    always_comb begin
        w_mrg = w_dw;
        for (int i = 0; i < W / 8; i++) begin
            if ((i >= w_lo) && (i < w_hi))
                w_mrg[8*i +: 8] = w_wd[8*i +: 8];
        end
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_load = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            F3_H:    o_load = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            F3_W:    o_load = w_sh;
            F3_BU:   o_load = {{(XLEN-8){1'b0}}, w_sh[7:0]};
            F3_HU:   o_load = {{(XLEN-16){1'b0}}, w_sh[15:0]};
            default: o_load = '0;
        endcase
    end

    assign o_wr0 = w_mrg[XLEN-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
    assign o_wr1 = w_mrg[W-1:XLEN];
`endif

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32 load/store master for a word-only data memory; sub-word
//               stores by read-modify-write. LSU_MISALIGN_SPLIT_EN enables
//               two-word split of misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    lsu_state_t      r_state;
    logic            r_store;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_buf0;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_rdata;
    logic            r_resp_err;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wd;

    logic [1:0]      w_off;
    logic [2:0]      w_size;
    logic [XLEN-1:0] w_w0;
    logic [XLEN-1:0] w_b0;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_wr0;
    logic [XLEN-1:0] w_req_w0;
    logic            w_req_ok;
    logic            w_req_sw_al;

    assign w_off    = r_addr[1:0];
    assign w_size   = f3_size(r_f3);
    assign w_w0     = {r_addr[XLEN-1:2], 2'b00};
    assign w_req_w0 = {req_addr[XLEN-1:2], 2'b00};

    // Lane inputs see the value being captured this cycle so outputs of the
    // next state can be registered at the same edge.
    assign w_b0 = (r_state == ST_RD0) ? mem_rd : r_buf0;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] r_buf1;
    logic [XLEN-1:0] w_b1;
    logic [XLEN-1:0] w_w1;
    logic [XLEN-1:0] w_wr1;
    logic            w_span;

    assign w_w1   = w_w0 + XLEN'(4);
    assign w_b1   = (r_state == ST_RD1) ? mem_rd : r_buf1;
    assign w_span = (({1'b0, w_off} + w_size) > 3'd4);
`endif

    always_comb begin
        w_req_ok = f3_legal(req_store, req_funct3);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (((f3_size(req_funct3) == 3'd2) && req_addr[0]) ||
            ((f3_size(req_funct3) == 3'd4) && (req_addr[1:0] != 2'b00)))
            w_req_ok = 1'b0;
`endif
    end

    assign w_req_sw_al = req_store && (req_funct3 == F3_W) && (req_addr[1:0] == 2'b00);

    lsu_byte_lane #(
        .XLEN     (XLEN)
    ) u_lane (
        .i_buf0   (w_b0),
`ifdef LSU_MISALIGN_SPLIT_EN
        .i_buf1   (w_b1),
        .o_wr1    (w_wr1),
`endif
        .i_wdata  (r_wdata),
        .i_off    (w_off),
        .i_size   (w_size),
        .i_funct3 (r_f3),
        .o_load   (w_load),
        .o_wr0    (w_wr0)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_store      <= 1'b0;
            r_f3         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_buf0       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_buf1       <= '0;
`endif
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_f3        <= req_funct3;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (!w_req_ok) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (w_req_sw_al) begin
                            r_state    <= ST_WR0;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_req_w0;
                            r_mem_wd   <= req_wdata;
                        end else begin
                            r_state    <= ST_RD0;
                            r_mem_addr <= w_req_w0;
                        end
                    end
                end
                ST_RD0: begin
                    r_buf0 <= mem_rd;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (w_span) begin
                        r_state    <= ST_RD1;
                        r_mem_addr <= w_w1;
                    end else
`endif
                    if (!r_store) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end else begin
                        r_state    <= ST_WR0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_w0;
                        r_mem_wd   <= w_wr0;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_RD1: begin
                    r_buf1 <= mem_rd;
                    if (!r_store) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end else begin
                        r_state    <= ST_WR0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_w0;
                        r_mem_wd   <= w_wr0;
                    end
                end
`endif
                ST_WR0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (w_span) begin
                        r_state    <= ST_WR1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_w1;
                        r_mem_wd   <= w_wr1;
                    end else
`endif
                    begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                ST_WR1: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wd     = r_mem_wd;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed vector bench for load_store_unit with a word memory
//               model; expectations follow LSU_MISALIGN_SPLIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic        pre_we = 1'b0;
    logic [31:0] pre_a = '0;
    logic [31:0] pre_d = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    load_store_unit #(.XLEN(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge CLK) begin
        if (pre_we)
            mem[pre_a[9:2]] <= pre_d;
        else if (mem_we)
            mem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(posedge CLK);
        #1 pre_we = 1'b0;
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nwe, output logic [31:0] last,
                           output logic busy_ok, output logic post_ok);
        @(negedge CLK);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        lat     = 1;
        nwe     = 0;
        last    = 32'hFFFF_FFFF;
        busy_ok = !req_ready;
        while (!resp_valid && lat < 20) begin
            if (mem_we) nwe++;
            last    = mem_addr;
            busy_ok = busy_ok && !req_ready && (resp_rdata == 32'h0) && !resp_err;
            @(posedge CLK);
            #1 lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge CLK);
        #1 post_ok = !resp_valid && (resp_rdata == 32'h0) && !resp_err && req_ready &&
                     !mem_we && (mem_addr == 32'h0) && (mem_wd == 32'h0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          nwe;
        logic [31:0] last;
        logic [31:0] caddr;
        logic [31:0] cval;
    } vec_t;

    vec_t tv [15];

    initial begin
        int          lat;
        int          nwe;
        logic [31:0] rd;
        logic [31:0] last;
        logic        er;
        logic        busy_ok;
        logic        post_ok;
        int          cyc;
        logic        saw_we;

        //        st    f3      addr           wdata          lat rdata          err nwe last           chk addr       chk value
        tv[0]  = '{1'b0, 3'b000, 32'h13,        32'h0,         2, 32'hFFFFFF88, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[1]  = '{1'b0, 3'b100, 32'h13,        32'h0,         2, 32'h00000088, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[2]  = '{1'b0, 3'b101, 32'h12,        32'h0,         2, 32'h00008899, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[3]  = '{1'b0, 3'b001, 32'h10,        32'h0,         2, 32'hFFFFAABB, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[4]  = '{1'b0, 3'b010, 32'h10,        32'h0,         2, 32'h8899AABB, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[5]  = '{1'b1, 3'b010, 32'h20,        32'hDEADBEEF,  2, 32'h0,        1'b0, 1, 32'h20,        32'h20,        32'hDEADBEEF};
        tv[6]  = '{1'b1, 3'b000, 32'h31,        32'h123456A5,  3, 32'h0,        1'b0, 1, 32'h30,        32'h30,        32'h1122A544};
        tv[7]  = '{1'b1, 3'b001, 32'h32,        32'hFFFF1234,  3, 32'h0,        1'b0, 1, 32'h30,        32'h30,        32'h1234A544};
        tv[8]  = '{1'b0, 3'b011, 32'h10,        32'h0,         1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h10,        32'h8899AABB};
        tv[9]  = '{1'b1, 3'b100, 32'h30,        32'hFFFFFFFF,  1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h30,        32'h1234A544};
`ifdef LSU_MISALIGN_SPLIT_EN
        tv[10] = '{1'b0, 3'b001, 32'h11,        32'h0,         2, 32'hFFFF99AA, 1'b0, 0, 32'h10,        32'h10,        32'h8899AABB};
        tv[11] = '{1'b0, 3'b010, 32'h42,        32'h0,         3, 32'h66554433, 1'b0, 0, 32'h44,        32'h40,        32'h44332211};
        tv[12] = '{1'b1, 3'b010, 32'h43,        32'hCAFEBABE,  5, 32'h0,        1'b0, 2, 32'h44,        32'h40,        32'hBE332211};
        tv[13] = '{1'b0, 3'b101, 32'h43,        32'h0,         3, 32'h0000BABE, 1'b0, 0, 32'h44,        32'h44,        32'h88CAFEBA};
        tv[14] = '{1'b0, 3'b010, 32'hFFFFFFFE,  32'h0,         3, 32'h56780BAD, 1'b0, 0, 32'h0,         32'h0,         32'h12345678};
`else
        tv[10] = '{1'b0, 3'b001, 32'h11,        32'h0,         1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h10,        32'h8899AABB};
        tv[11] = '{1'b0, 3'b010, 32'h42,        32'h0,         1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h40,        32'h44332211};
        tv[12] = '{1'b1, 3'b010, 32'h43,        32'hCAFEBABE,  1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h40,        32'h44332211};
        tv[13] = '{1'b0, 3'b101, 32'h43,        32'h0,         1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h44,        32'h88776655};
        tv[14] = '{1'b0, 3'b010, 32'hFFFFFFFE,  32'h0,         1, 32'h0,        1'b1, 0, 32'hFFFFFFFF,  32'h0,         32'h12345678};
`endif

        // Memory is preloaded while the DUT is held in reset.
        RST_N = 1'b0;
        preset(32'h10,       32'h8899AABB);
        preset(32'h30,       32'h11223344);
        preset(32'h40,       32'h44332211);
        preset(32'h44,       32'h88776655);
        preset(32'hFFFFFFFC, 32'h0BADF00D);
        preset(32'h0,        32'h12345678);

        chk("reset req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset resp_err",   {31'h0, resp_err},   32'h0);
        chk("reset resp_rdata", resp_rdata,          32'h0);
        chk("reset mem_we",     {31'h0, mem_we},     32'h0);
        chk("reset mem_addr",   mem_addr,            32'h0);
        chk("reset mem_wd",     mem_wd,              32'h0);

        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_req(tv[i].st, tv[i].f3, tv[i].addr, tv[i].wd, lat, rd, er, nwe, last, busy_ok, post_ok);
            chk($sformatf("vec%0d latency", i),   32'(lat),              32'(tv[i].lat));
            chk($sformatf("vec%0d rdata", i),     rd,                    tv[i].rd);
            chk($sformatf("vec%0d err", i),       {31'h0, er},           {31'h0, tv[i].er});
            chk($sformatf("vec%0d we_cycles", i), 32'(nwe),              32'(tv[i].nwe));
            chk($sformatf("vec%0d last_addr", i), last,                  tv[i].last);
            chk($sformatf("vec%0d busy", i),      {31'h0, busy_ok},      32'h1);
            chk($sformatf("vec%0d after", i),     {31'h0, post_ok},      32'h1);
            chk($sformatf("vec%0d memory", i),    mem[tv[i].caddr[9:2]], tv[i].cval);
        end

        // Reset asserted while a write cycle is on the bus.
        @(negedge CLK);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr   = 32'h46;
`else
        req_addr   = 32'h24;
`endif
        req_wdata  = 32'h11112222;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        saw_we = 1'b0;
        for (cyc = 0; cyc < 20 && !saw_we; cyc++) begin
            if (mem_we) saw_we = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        chk("abort reached write", {31'h0, saw_we}, 32'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("abort mem_we",    {31'h0, mem_we},    32'h0);
        chk("abort req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort mem_addr",  mem_addr,           32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("abort w0 kept", mem[8'h11], 32'h88CAFEBA);
        chk("abort w1 kept", mem[8'h12], 32'h0);
`else
        chk("abort word kept", mem[8'h09], 32'h0);
`endif
        chk("abort ready after", {31'h0, req_ready}, 32'h1);

        run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, nwe, last, busy_ok, post_ok);
        chk("post-abort latency", 32'(lat),         32'd2);
        chk("post-abort rdata",   rd,               32'h8899AABB);
        chk("post-abort err",     {31'h0, er},      32'h0);
        chk("post-abort after",   {31'h0, post_ok}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
